uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter DIV_RST, default 16'd0, reset value of the divisor register.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_rs  input  1  byte-available level from the receiver unit.
REQ-006 SHALL have port rx_d  input  8  received byte from the receiver unit.
REQ-007 SHALL have port rx_en  output  1  sample-tick enable to the receiver unit.
REQ-008 SHALL have port rx_over_read  output  1  one-cycle byte-consumed pulse to the receiver unit.
REQ-009 SHALL have port sel  input  1  CPU register access strobe.
REQ-010 SHALL have port we  input  1  CPU write when 1, read when 0.
REQ-011 SHALL have port addr  input  2  register index: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL.
REQ-012 SHALL have port wdata  input  32  CPU write data.
REQ-013 SHALL have port rdata  output  32  CPU read data, combinational from addr.
REQ-014 SHALL have port irq  output  1  receive interrupt request.

Function
REQ-015 Baud tick: 16-bit down-counter; while counter != 0, decrement; at 0, rx_en = 1 for that cycle and counter reloads DIV.
REQ-016 When DIV = 0, rx_en SHALL be 1 every cycle.
REQ-017 A write to DIV SHALL also load the counter with wdata[15:0]; the tick resumes from the new value on the next cycle.
REQ-018 Drain FSM states: IDLE, CAPTURE, WAIT_CLR.
REQ-019 IDLE -> CAPTURE when rx_rs = 1.
REQ-020 CAPTURE: push rx_d if the FIFO is not full, else set sticky overrun and drop the byte; rx_over_read = 1 this cycle only; -> WAIT_CLR.
REQ-021 WAIT_CLR: rx_over_read = 0; -> IDLE when rx_rs = 0.
REQ-022 rx_over_read SHALL never be high for two consecutive cycles.
REQ-023 DATA read (sel & !we & addr = 0): rdata = {24'b0, head byte}; the FIFO pops at that clock edge; an empty read returns 0 and changes nothing.
REQ-024 STATUS read: rdata = {overrun[8], full[7], nonempty[6], 1'b0[5], count[4:0]}, all other bits 0.
REQ-025 Writing STATUS with wdata[8] = 1 SHALL clear overrun; writes to DATA SHALL be ignored.
REQ-026 DIV read: {16'b0, DIV}. CTRL read: {31'b0, ie}; a CTRL write sets ie = wdata[0].
REQ-027 A push and a pop in the same cycle SHALL both take effect and leave count unchanged; a push into a full FIFO SHALL not happen even if a pop occurs in that cycle.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-029 When the CPU is idle (sel = 0), rdata SHALL be 0.

Reset
REQ-030 On rst_n low: FSM = IDLE, FIFO empty, pointers and count 0, overrun 0, ie 0, DIV = DIV_RST, counter = DIV_RST.
REQ-031 During reset: rx_en = 0, rx_over_read = 0, irq = 0.
REQ-032 Reset asserted mid-CAPTURE SHALL abort the capture; the byte is lost and no pulse is issued after release.
REQ-033 After release, the FSM SHALL re-evaluate rx_rs from IDLE.

Configuration
REQ-034 Macro UART_RX_IRQ_EN defined: irq = ie & (nonempty | overrun), combinational.
REQ-035 Macro UART_RX_IRQ_EN undefined: irq tied to 0; the CTRL register reads 0 and ignores writes; everything else is unchanged.

Verification
REQ-036 DIV = 3 after reset -> rx_en pulses one cycle in every 4, first pulse 4 cycles after the write.
REQ-037 rx_rs rises with rx_d = 8'hA5 -> one rx_over_read pulse 1 cycle later; STATUS = 0x41; DATA read returns 0xA5; STATUS then reads 0x00.
REQ-038 Five bytes 01..05 with no reads, FIFO_DEPTH = 4 -> STATUS = 0x1C4; reads return 01..04, then 0; writing 0x100 to STATUS clears bit 8.
REQ-039 FIFO holding 2 entries, and a push and a DATA read in the same cycle -> count stays 2; byte order is preserved.
REQ-040 With UART_RX_IRQ_EN, ie = 1 and one byte received -> irq = 1; after the DATA read irq = 0; with the macro undefined, irq stays 0 throughout.
REQ-041 rst_n pulsed low while in CAPTURE -> all outputs 0 immediately; after release with rx_rs still 1, exactly one capture and one pulse occur.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: baud tick, byte drain FSM, receive FIFO, CPU registers; optional irq via UART_RX_IRQ_EN
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RST    = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rs,
    input  logic [7:0]  rx_d,
    output logic        rx_en,
    output logic        rx_over_read,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       cnt;
    logic [15:0]       div;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [4:0]        count;
    logic              overrun;
    logic              ie;
    logic              full;
    logic              nonempty;
    logic              wr_sel;
    logic              pop;
    logic              push;
    logic              unused_wdata_hi;

    assign full            = (count == DEPTH_C);
    assign nonempty        = (count != 5'd0);
    assign wr_sel          = sel & we;
    assign pop             = sel & ~we & (addr == 2'd0) & nonempty;
    assign push            = rx_over_read & ~full;
    assign unused_wdata_hi = &{1'b0, wdata[31:16]};

    // Sample tick is forced low while reset is held, even if the counter sits at zero
    assign rx_en = rst_n & (cnt == 16'd0);

    // Divisor register and baud down-counter; a DIV write restarts the count immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= DIV_RST;
            cnt <= DIV_RST;
        end else if (wr_sel && (addr == 2'd2)) begin
            div <= wdata[15:0];
            cnt <= wdata[15:0];
        end else if (cnt == 16'd0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Drain FSM next state: capture once per rx_rs assertion, then wait for it to drop
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_rs) state_nxt = CAPTURE;
            CAPTURE:  state_nxt = WAIT_CLR;
            WAIT_CLR: if (!rx_rs) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Drain FSM outputs: consume pulse only in the single CAPTURE cycle
    always_comb begin
        rx_over_read = 1'b0;
        if (state == CAPTURE) rx_over_read = 1'b1;
    end

    // FIFO storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_d;
    end

    // FIFO pointers, occupancy and sticky overrun; a new overrun wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= 5'd0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {4'b0, push} - {4'b0, pop};
            if (rx_over_read && full)
                overrun <= 1'b1;
            else if (wr_sel && (addr == 2'd1) && wdata[8])
                overrun <= 1'b0;
        end
    end

`ifdef UART_RX_IRQ_EN
    // Interrupt enable bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ie <= 1'b0;
        else if (wr_sel && (addr == 2'd3))  ie <= wdata[0];
    end

    assign irq = ie & (nonempty | overrun);
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    // Register read mux; zero whenever the CPU is not selecting
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr)
                2'd0: if (nonempty) rdata = {24'd0, mem[rd_ptr]};
                2'd1: rdata = {23'd0, overrun, full, nonempty, 1'b0, count};
                2'd2: rdata = {16'd0, div};
                default: rdata = {31'd0, ie};
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_rs;
    logic [7:0]  rx_d;
    logic        rx_en;
    logic        rx_over_read;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int passed;
    int total;
    int pulse_cnt;
    int double_cnt;
    logic prev_ror;

    uart_rx_ctrl #(.FIFO_DEPTH(4), .DIV_RST(16'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_rs        (rx_rs),
        .rx_d         (rx_d),
        .rx_en        (rx_en),
        .rx_over_read (rx_over_read),
        .sel          (sel),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_over_read) pulse_cnt++;
        if (rx_over_read && prev_ror) double_cnt++;
        prev_ror = rx_over_read;
    end

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        #1 d = rdata;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_d = b; rx_rs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rx_rs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0; rx_rs = 1'b0; rx_d = 8'd0;
        sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (rx_en !== 1'b0) $display("FAIL reset_rx_en got=%b exp=0", rx_en); else passed++;
        total++; if (rx_over_read !== 1'b0) $display("FAIL reset_ror got=%b exp=0", rx_over_read); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++; if (rx_en !== 1'b1) $display("FAIL div0_rx_en got=%b exp=1", rx_en); else passed++;
        total++; if (rdata !== 32'd0) $display("FAIL idle_rdata got=%h exp=0", rdata); else passed++;
        cpu_rd(2'd1, d);
        total++; if (d !== 32'd0) $display("FAIL reset_status got=%h exp=0", d); else passed++;
        cpu_rd(2'd2, d);
        total++; if (d !== 32'd0) $display("FAIL reset_div got=%h exp=0", d); else passed++;
        cpu_rd(2'd3, d);
        total++; if (d !== 32'd0) $display("FAIL reset_ctrl got=%h exp=0", d); else passed++;
    endtask

    task automatic test_baud;
        logic [31:0] d;
        cpu_wr(2'd2, 32'hFFFF_0003);
        for (int k = 0; k < 9; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            total++;
            if (rx_en !== ((k % 4) == 3))
                $display("FAIL baud_tick_%0d got=%b exp=%b", k, rx_en, ((k % 4) == 3));
            else passed++;
        end
        cpu_rd(2'd2, d);
        total++; if (d !== 32'h3) $display("FAIL div_read got=%h exp=3", d); else passed++;
        cpu_wr(2'd2, 32'd0);
        #1;
        total++; if (rx_en !== 1'b1) $display("FAIL div0_again got=%b exp=1", rx_en); else passed++;
    endtask

    task automatic test_single_byte;
        logic [31:0] d;
        int base;
        @(negedge clk);
        base = pulse_cnt;
        rx_d = 8'hA5; rx_rs = 1'b1;
        #1;
        total++; if (rx_over_read !== 1'b0) $display("FAIL ror_early got=%b exp=0", rx_over_read); else passed++;
        @(negedge clk); #1;
        total++; if (rx_over_read !== 1'b1) $display("FAIL ror_pulse got=%b exp=1", rx_over_read); else passed++;
        @(negedge clk); #1;
        total++; if (rx_over_read !== 1'b0) $display("FAIL ror_single got=%b exp=0", rx_over_read); else passed++;
        rx_rs = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (pulse_cnt - base !== 1) $display("FAIL pulse_count got=%0d exp=1", pulse_cnt - base); else passed++;
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h41) $display("FAIL a5_status got=%h exp=41", d); else passed++;
        cpu_rd(2'd0, d);
        total++; if (d !== 32'hA5) $display("FAIL a5_data got=%h exp=a5", d); else passed++;
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h0) $display("FAIL a5_status_after got=%h exp=0", d); else passed++;
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h1C4) $display("FAIL ovr_status got=%h exp=1c4", d); else passed++;
        for (int i = 1; i <= 4; i++) begin
            cpu_rd(2'd0, d);
            total++; if (d !== 32'(i)) $display("FAIL ovr_data_%0d got=%h exp=%h", i, d, i); else passed++;
        end
        cpu_rd(2'd0, d);
        total++; if (d !== 32'h0) $display("FAIL empty_read got=%h exp=0", d); else passed++;
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h100) $display("FAIL ovr_sticky got=%h exp=100", d); else passed++;
        cpu_wr(2'd0, 32'h77);
        cpu_wr(2'd1, 32'h100);
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h0) $display("FAIL ovr_clear got=%h exp=0", d); else passed++;
    endtask

    task automatic test_push_pop;
        logic [31:0] d;
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rx_d = 8'h33; rx_rs = 1'b1;
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 2'd0;
        #1;
        total++; if (rdata !== 32'h11) $display("FAIL pp_head got=%h exp=11", rdata); else passed++;
        @(negedge clk);
        sel = 1'b0; rx_rs = 1'b0;
        @(negedge clk);
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h42) $display("FAIL pp_count got=%h exp=42", d); else passed++;
        cpu_rd(2'd0, d);
        total++; if (d !== 32'h22) $display("FAIL pp_order1 got=%h exp=22", d); else passed++;
        cpu_rd(2'd0, d);
        total++; if (d !== 32'h33) $display("FAIL pp_order2 got=%h exp=33", d); else passed++;
    endtask

    task automatic test_full_pop;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        @(negedge clk);
        rx_d = 8'hA4; rx_rs = 1'b1;
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 2'd0;
        #1;
        total++; if (rdata !== 32'hA0) $display("FAIL fp_head got=%h exp=a0", rdata); else passed++;
        @(negedge clk);
        sel = 1'b0; rx_rs = 1'b0;
        @(negedge clk);
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h143) $display("FAIL fp_status got=%h exp=143", d); else passed++;
        for (int i = 1; i < 4; i++) begin
            cpu_rd(2'd0, d);
            total++; if (d !== 32'hA0 + 32'(i)) $display("FAIL fp_data_%0d got=%h exp=%h", i, d, 32'hA0 + 32'(i)); else passed++;
        end
        cpu_wr(2'd1, 32'h100);
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h0) $display("FAIL fp_clear got=%h exp=0", d); else passed++;
    endtask

    task automatic test_irq;
        logic [31:0] d;
        cpu_wr(2'd3, 32'h1);
        cpu_rd(2'd3, d);
`ifdef UART_RX_IRQ_EN
        total++; if (d !== 32'h1) $display("FAIL ctrl_read got=%h exp=1", d); else passed++;
        #1;
        total++; if (irq !== 1'b0) $display("FAIL irq_empty got=%b exp=0", irq); else passed++;
        send_byte(8'h5C);
        #1;
        total++; if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else passed++;
`else
        total++; if (d !== 32'h0) $display("FAIL ctrl_read got=%h exp=0", d); else passed++;
        send_byte(8'h5C);
        #1;
        total++; if (irq !== 1'b0) $display("FAIL irq_off got=%b exp=0", irq); else passed++;
`endif
        cpu_rd(2'd0, d);
        total++; if (d !== 32'h5C) $display("FAIL irq_data got=%h exp=5c", d); else passed++;
        #1;
        total++; if (irq !== 1'b0) $display("FAIL irq_clr got=%b exp=0", irq); else passed++;
    endtask

    task automatic test_reset_mid_capture;
        logic [31:0] d;
        int base;
        send_byte(8'hEE);
        @(negedge clk);
        rx_d = 8'h5A; rx_rs = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (rx_over_read !== 1'b0) $display("FAIL mid_ror got=%b exp=0", rx_over_read); else passed++;
        total++; if (rx_en !== 1'b0) $display("FAIL mid_rx_en got=%b exp=0", rx_en); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL mid_irq got=%b exp=0", irq); else passed++;
        @(negedge clk);
        @(negedge clk);
        base = pulse_cnt;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++; if (pulse_cnt - base !== 1) $display("FAIL mid_pulses got=%0d exp=1", pulse_cnt - base); else passed++;
        cpu_rd(2'd1, d);
        total++; if (d !== 32'h41) $display("FAIL mid_status got=%h exp=41", d); else passed++;
        rx_rs = 1'b0;
        cpu_rd(2'd0, d);
        total++; if (d !== 32'h5A) $display("FAIL mid_data got=%h exp=5a", d); else passed++;
        cpu_rd(2'd3, d);
        total++; if (d !== 32'h0) $display("FAIL mid_ie got=%h exp=0", d); else passed++;
    endtask

    initial begin
        passed = 0; total = 0; pulse_cnt = 0; double_cnt = 0; prev_ror = 1'b0;
        test_reset;
        test_baud;
        test_single_byte;
        test_overrun;
        test_push_pop;
        test_full_pop;
        test_irq;
        test_reset_mid_capture;
        total++; if (double_cnt !== 0) $display("FAIL ror_back_to_back got=%0d exp=0", double_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
